// File: rtl/hw_splitter_pkg.sv
// Shared constants for the halfword splitter: word geometry, halfword field
// boundaries, FSM state encodings and the half-select helpers.
package hw_splitter_pkg;

    localparam int HW_W   = 5;
    localparam int WORD_W = 10;

    localparam int UPPER_MSB = 9;
    localparam int UPPER_LSB = 5;
    localparam int LOWER_MSB = 4;
    localparam int LOWER_LSB = 0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FIRST  = 2'd1;
    localparam logic [1:0] ST_SECOND = 2'd2;

    function automatic logic [HW_W-1:0] upper_half(input logic [WORD_W-1:0] word);
        return word[UPPER_MSB:UPPER_LSB];
    endfunction

    function automatic logic [HW_W-1:0] lower_half(input logic [WORD_W-1:0] word);
        return word[LOWER_MSB:LOWER_LSB];
    endfunction

endpackage

// File: rtl/hw_splitter.sv
// Splits each accepted 10-bit word into two 5-bit halves sent in a selectable
// order over a valid/ready output port, counting fully sent words.
module hw_splitter
    import hw_splitter_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_word,
    input  logic                in_lo_first,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [HW_W-1:0]     out_hw,
    output logic                out_is_upper,
    output logic                out_last,
    output logic [CNT_W-1:0]    word_count
);

    logic [1:0]        state;
    logic [WORD_W-1:0] hold_word;
    logic              hold_lo_first;
    logic              in_xfer;
    logic              out_xfer;
    logic              bad_state;

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        in_ready  = (state == ST_IDLE) || ((state == ST_SECOND) && out_ready);
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
        bad_state = (state != ST_IDLE) && (state != ST_FIRST) && (state != ST_SECOND);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            hold_word     <= '0;
            hold_lo_first <= 1'b0;
            out_valid     <= 1'b0;
            out_hw        <= '0;
            out_is_upper  <= 1'b0;
            out_last      <= 1'b0;
            word_count    <= '0;
        end else begin
            if ((state == ST_SECOND) && out_xfer) begin
                word_count <= word_count + CNT_W'(1);
            end

            if (in_xfer) begin
                // New word: latch it and present its first half next cycle.
                state         <= ST_FIRST;
                hold_word     <= in_word;
                hold_lo_first <= in_lo_first;
                out_valid     <= 1'b1;
                out_hw        <= in_lo_first ? lower_half(in_word) : upper_half(in_word);
                out_is_upper  <= !in_lo_first;
                out_last      <= 1'b0;
            end else if ((state == ST_FIRST) && out_xfer) begin
                state        <= ST_SECOND;
                out_hw       <= hold_lo_first ? upper_half(hold_word) : lower_half(hold_word);
                out_is_upper <= hold_lo_first;
                out_last     <= 1'b1;
            end else if (((state == ST_SECOND) && out_xfer) || bad_state) begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
